// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA copper (display-list sequencer).
package vga_pkg;

  // Command opcodes, stored in entry bits [39:38]
  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_DELAY = 2'd1;
  localparam logic [1:0] OP_END   = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  // Upper address byte of the VGA core register window
  localparam logic [7:0] VGA_BASE = 8'h04;

  // VGA core register offsets
  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_STATUS    = 8'h04;
  localparam logic [7:0] REG_HTIM      = 8'h08;
  localparam logic [7:0] REG_VTIM      = 8'h0C;
  localparam logic [7:0] REG_HVLEN     = 8'h10;
  localparam logic [7:0] REG_BG_COLOR  = 8'h14;
  localparam logic [7:0] REG_WAIT_COND = 8'h18;
  localparam logic [7:0] REG_BEAM_POS  = 8'h1C;
  localparam logic [7:0] REG_SPR0_POS  = 8'h20;
  localparam logic [7:0] REG_SPR0_ADDR = 8'h24;
  localparam logic [7:0] REG_SPR1_POS  = 8'h28;
  localparam logic [7:0] REG_SPR1_ADDR = 8'h2C;
  localparam logic [7:0] REG_PAL_IDX   = 8'h30;
  localparam logic [7:0] REG_PAL_DATA  = 8'h34;
  localparam logic [7:0] REG_CUR_POS   = 8'h38;
  localparam logic [7:0] REG_CUR_COLOR = 8'h3C;
  localparam logic [7:0] REG_FB0_BASE  = 8'h40;
  localparam logic [7:0] REG_FB1_BASE  = 8'h44;
  localparam logic [7:0] REG_SCROLL_X  = 8'h48;
  localparam logic [7:0] REG_SCROLL_Y  = 8'h4C;
  localparam logic [7:0] REG_INT_MASK  = 8'h50;

  // Internal RAM word: {offset[7:0], op[1:0], reserved[5:0], payload[31:0]}
  localparam int RAM_W = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_GAP,
    ST_DELAY
  } state_e;

endpackage

// File: rtl/vga_cmd_ram.sv
// Command list storage: simple dual-port RAM, one write port, one
// registered read port (data valid the cycle after the address).
module vga_cmd_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 48
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;

  // Contents are intentionally not reset; read returns the pre-write word on a collision
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_copper.sv
// Display-list sequencer mastering the VGA core Wishbone slave.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | halted, waiting for start
// FETCH  | pc presented to RAM; pending stop halts here
// DECODE | RAM word valid, dispatch on opcode
// ISSUE  | Wishbone write in flight, waiting for ack or watchdog
// GAP    | strobe low for one cycle so the slave's stale ack clears
// DELAY  | counting down a DELAY entry
module vga_copper
  import vga_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int AW        = 6,
  parameter int TIMEOUT_W = 21
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [39:0]   load_data,
  input  logic [7:0]    load_off,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] pc,
  output logic [31:0]   wb_addr_o,
  output logic [31:0]   wb_data_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_stb_o,
  output logic          wb_cyc_o,
  input  logic          wb_ack_i
);

  // Watchdog reload: reaching zero takes 2^TIMEOUT_W-1 strobe cycles in ISSUE
  localparam logic [TIMEOUT_W-1:0] WDOG_LOAD = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_e               state_q, state_d;
  logic [AW-1:0]        pc_q, pc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 stb_q, stb_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic [19:0]          dly_q, dly_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

  logic [RAM_W-1:0]     ram_rd;
  logic [1:0]           op;
  logic [31:0]          payload;
  logic [7:0]           off;
  logic                 unused_rsvd;

  // The list cannot be rewritten underneath a running sequence
  vga_cmd_ram #(.DEPTH(DEPTH), .AW(AW), .W(RAM_W)) u_ram (
    .clk     (clk),
    .we      (load_we & ~busy_q),
    .wr_addr (load_addr),
    .wr_data ({load_off, load_data}),
    .rd_addr (pc_q),
    .rd_data (ram_rd)
  );

  assign off         = ram_rd[47:40];
  assign op          = ram_rd[39:38];
  assign payload     = ram_rd[31:0];
  assign unused_rsvd = ^ram_rd[37:32];

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      stop_pend_q <= 1'b0;
      stb_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      dly_q       <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      stop_pend_q <= stop_pend_d;
      stb_q       <= stb_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      dly_q       <= dly_d;
      wdog_q      <= wdog_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  state_d = stop_pend_q ? ST_IDLE : ST_DECODE;
      ST_DECODE: begin
        unique case (op)
          OP_WRITE: state_d = ST_ISSUE;
          OP_DELAY: state_d = (payload[19:0] == 20'd0) ? ST_FETCH : ST_DELAY;
          OP_END:   state_d = loop_en ? ST_FETCH : ST_IDLE;
          default:  state_d = ST_FETCH;
        endcase
      end
      ST_ISSUE: begin
        if (wb_ack_i)                 state_d = ST_GAP;
        else if (wdog_q == '0)        state_d = ST_IDLE;
      end
      ST_GAP:    state_d = ST_FETCH;
      ST_DELAY:  if (dly_q == 20'd1) state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Per-state register updates: pc, status flags, bus outputs, timers
  always_comb begin
    pc_d        = pc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    stop_pend_d = stop_pend_q | stop;
    stb_d       = stb_q;
    addr_d      = addr_q;
    data_d      = data_q;
    dly_d       = dly_q;
    wdog_d      = wdog_q;
    unique case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          pc_d    = '0;
          busy_d  = 1'b1;
          error_d = 1'b0;
        end
      end
      ST_FETCH: begin
        if (stop_pend_q) begin
          busy_d      = 1'b0;
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end
      end
      ST_DECODE: begin
        unique case (op)
          OP_WRITE: begin
            addr_d = {VGA_BASE, 16'h0000, off};
            data_d = payload;
            stb_d  = 1'b1;
            wdog_d = WDOG_LOAD;
          end
          OP_DELAY: begin
            if (payload[19:0] == 20'd0) pc_d = pc_q + AW'(1);
            else                        dly_d = payload[19:0];
          end
          OP_END: begin
            if (loop_en) begin
              pc_d = '0;
            end else begin
              busy_d      = 1'b0;
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
            end
          end
          default: pc_d = pc_q + AW'(1);
        endcase
      end
      ST_ISSUE: begin
        if (wb_ack_i) begin
          stb_d = 1'b0;
          pc_d  = pc_q + AW'(1);
        end else if (wdog_q == '0) begin
          stb_d       = 1'b0;
          error_d     = 1'b1;
          busy_d      = 1'b0;
          stop_pend_d = 1'b0;
        end else begin
          wdog_d = wdog_q - TIMEOUT_W'(1);
        end
      end
      ST_GAP: ;
      ST_DELAY: begin
        if (dly_q == 20'd1) pc_d = pc_q + AW'(1);
        else                dly_d = dly_q - 20'd1;
      end
      default: ;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign pc        = pc_q;
  assign wb_addr_o = addr_q;
  assign wb_data_o = data_q;
  assign wb_sel_o  = 4'hF;
  assign wb_we_o   = 1'b1;
  assign wb_stb_o  = stb_q;
  assign wb_cyc_o  = stb_q;

endmodule

// File: tb/tb_vga_copper.sv
// Scoreboard bench for vga_copper: directed command lists, a Wishbone slave
// model with programmable ack latency, and a monitor checking each write.
module tb_vga_copper;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, load_we, start, stop, loop_en;
  logic [5:0]  load_addr;
  logic [39:0] load_data;
  logic [7:0]  load_off;
  logic        busy, done, error;
  logic [5:0]  pc;
  logic [31:0] wb_addr_o, wb_data_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic        wb_ack_i = 1'b0;

  // Second instance with a short watchdog
  logic        w_start, w_ack;
  logic        w_busy, w_done, w_error;
  logic [5:0]  w_pc;
  logic [31:0] w_addr, w_data;
  logic [3:0]  w_sel;
  logic        w_we, w_stb, w_cyc;

  vga_copper u_dut (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .load_off(load_off), .start(start), .stop(stop),
    .loop_en(loop_en), .busy(busy), .done(done), .error(error), .pc(pc),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  vga_copper #(.TIMEOUT_W(4)) u_dut_wd (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .load_off(load_off), .start(w_start), .stop(stop),
    .loop_en(loop_en), .busy(w_busy), .done(w_done), .error(w_error), .pc(w_pc),
    .wb_addr_o(w_addr), .wb_data_o(w_data), .wb_sel_o(w_sel),
    .wb_we_o(w_we), .wb_stb_o(w_stb), .wb_cyc_o(w_cyc), .wb_ack_i(w_ack)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;   // strobe-high cycles, ack latency + 1
    int          gap;    // strobe-low cycles before this write, 0 = unchecked
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   n_txn = 0;
  int   stb_rise_cyc = 0;
  int   w_n_done = 0;

  always @(negedge clk) if (w_done === 1'b1) w_n_done++;

  // Slave model and monitor: ack after the queued latency, ack held while
  // strobe is high and released one cycle after strobe drops
  logic        stb_prev = 1'b0;
  int          hold_cnt = 0, gap_cnt = 0, last_gap = 0, slv_cnt = 0, drop_cnt = 0;
  logic [31:0] rise_addr, rise_data;
  bit          unstable;
  always @(negedge clk) begin
    int   lat;
    exp_t e;
    if (wb_stb_o === 1'b1) begin
      if (!stb_prev) begin
        rise_addr = wb_addr_o; rise_data = wb_data_o; unstable = 0;
        hold_cnt = 0; slv_cnt = 0; stb_rise_cyc = cyc; last_gap = gap_cnt;
      end
      hold_cnt++;
      if (wb_addr_o !== rise_addr || wb_data_o !== rise_data || wb_cyc_o !== 1'b1
          || wb_sel_o !== 4'hF || wb_we_o !== 1'b1) unstable = 1;
      lat = (lat_q.size() > 0) ? lat_q[0] : 0;
      if (!wb_ack_i) begin
        if (slv_cnt >= lat) wb_ack_i = 1'b1;
        else slv_cnt++;
      end
      if (wb_ack_i) begin
        n_txn++;
        if (lat_q.size() > 0) void'(lat_q.pop_front());
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_txn: got addr 0x%0h data 0x%0h, expected none", wb_addr_o, wb_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("txn_addr", wb_addr_o, e.addr);
          chk("txn_data", wb_data_o, e.data);
          chk("txn_hold", hold_cnt, e.hold);
          chk("txn_stable", unstable, 0);
          if (e.gap > 0) chk("txn_gap", last_gap, e.gap);
        end
      end
      drop_cnt = 0; gap_cnt = 0;
    end else begin
      gap_cnt++;
      if (wb_ack_i) begin
        if (drop_cnt >= 1) wb_ack_i = 1'b0;
        else drop_cnt++;
      end
    end
    stb_prev = (wb_stb_o === 1'b1);
  end

  task automatic load(input logic [5:0] a, input logic [1:0] op, input logic [31:0] p,
                      input logic [7:0] off);
    load_we = 1'b1; load_addr = a; load_data = {op, 6'b0, p}; load_off = off;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic do_start(output int sc);
    start = 1'b1; sc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int bound, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < bound; i++) begin
      if (done === 1'b1) begin dcyc = cyc; break; end
      @(negedge clk);
    end
    if (dcyc < 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no done within %0d cycles, expected a pulse", nm, bound);
    end else begin
      @(negedge clk);
      chk({nm, "_single"}, done, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int sc, dc, base, r0, r1, cnt;
    reset = 0; load_we = 0; load_addr = 0; load_data = 0; load_off = 0;
    start = 0; stop = 0; loop_en = 0; w_start = 0; w_ack = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_error", error, 0); chk("rst_pc", pc, 0);
    chk("rst_stb", wb_stb_o, 0); chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_addr", wb_addr_o, 0); chk("rst_data", wb_data_o, 0);
    reset = 1;
    @(negedge clk);

    // Single write then END
    load(0, OP_WRITE, 32'h00F0_0ABC, REG_BEAM_POS);
    load(1, OP_END, 32'h0, 8'h00);
    exp_q.push_back('{32'h0400_001C, 32'h00F0_0ABC, 1, 0}); lat_q.push_back(0);
    base = n_txn;
    do_start(sc);
    wait_done("t1_done", 100, dc);
    chk("t1_stb_latency", stb_rise_cyc - sc, 3);
    chk("t1_done_after_stb", dc - stb_rise_cyc, 4);
    chk("t1_busy", busy, 0);
    chk("t1_pc", pc, 1);
    chk("t1_ntxn", n_txn - base, 1);

    // Back-to-back writes need the idle gap
    load(0, OP_WRITE, 32'h1111_1111, REG_SPR0_POS);
    load(1, OP_WRITE, 32'h2222_2222, REG_SPR0_ADDR);
    load(2, OP_END, 32'h0, 8'h00);
    exp_q.push_back('{32'h0400_0020, 32'h1111_1111, 1, 0});
    exp_q.push_back('{32'h0400_0024, 32'h2222_2222, 1, 3});
    lat_q.push_back(0); lat_q.push_back(0);
    base = n_txn;
    do_start(sc);
    wait_done("t2_done", 100, dc);
    chk("t2_ntxn", n_txn - base, 2);
    chk("t2_pc", pc, 2);

    // Wait-condition write held off by the slave for 500 cycles
    load(0, OP_WRITE, 32'h0300_0064, REG_WAIT_COND);
    load(1, OP_WRITE, 32'h0000_0001, REG_BEAM_POS);
    exp_q.push_back('{32'h0400_0018, 32'h0300_0064, 501, 0});
    exp_q.push_back('{32'h0400_001C, 32'h0000_0001, 1, 3});
    lat_q.push_back(500); lat_q.push_back(0);
    base = n_txn;
    do_start(sc);
    wait_done("t3_done", 1000, dc);
    chk("t3_ntxn", n_txn - base, 2);
    chk("t3_error", error, 0);

    // DELAY 0 versus DELAY 10 ahead of a write
    load(0, OP_DELAY, 32'd0, 8'h00);
    load(1, OP_WRITE, 32'hAAAA_5555, REG_VTIM);
    load(2, OP_END, 32'h0, 8'h00);
    exp_q.push_back('{32'h0400_000C, 32'hAAAA_5555, 1, 0}); lat_q.push_back(0);
    do_start(sc);
    wait_done("t4a_done", 100, dc);
    r0 = stb_rise_cyc - sc;
    chk("t4_nodelay_latency", r0, 5);
    load(0, OP_DELAY, 32'd10, 8'h00);
    exp_q.push_back('{32'h0400_000C, 32'hAAAA_5555, 1, 0}); lat_q.push_back(0);
    do_start(sc);
    wait_done("t4b_done", 100, dc);
    r1 = stb_rise_cyc - sc;
    chk("t4_delay_latency", r1, 15);
    chk("t4_delay_diff", r1 - r0, 10);

    // Watchdog on the short-timeout instance, slave never acks
    load(0, OP_WRITE, 32'h0000_0005, REG_PAL_IDX);
    load(1, OP_END, 32'h0, 8'h00);
    base = w_n_done;
    w_start = 1'b1; @(negedge clk); w_start = 1'b0;
    for (int i = 0; i < 20 && w_stb !== 1'b1; i++) @(negedge clk);
    cnt = 0;
    while (w_stb === 1'b1 && cnt < 40) begin cnt++; @(negedge clk); end
    chk("t5_stb_cycles", cnt, 15);
    chk("t5_error", w_error, 1);
    chk("t5_busy", w_busy, 0);
    repeat (3) @(negedge clk);
    chk("t5_no_done", w_n_done - base, 0);
    w_start = 1'b1; @(negedge clk); w_start = 1'b0;
    chk("t5_error_cleared", w_error, 0);
    chk("t5_busy_restart", w_busy, 1);
    for (int i = 0; i < 40 && w_busy === 1'b1; i++) @(negedge clk);

    // Looping list, stop during ISSUE, load attempt while busy
    loop_en = 1'b1;
    load(0, OP_WRITE, 32'h1234_5678, REG_FB0_BASE);
    load(1, OP_END, 32'h0, 8'h00);
    exp_q.push_back('{32'h0400_0040, 32'h1234_5678, 1, 0});
    exp_q.push_back('{32'h0400_0040, 32'h1234_5678, 21, 5});
    lat_q.push_back(0); lat_q.push_back(20);
    base = n_txn;
    do_start(sc);
    for (int i = 0; i < 50 && n_txn - base < 1; i++) @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 50 && wb_stb_o !== 1'b1; i++) @(negedge clk);
    chk("t6_in_issue", wb_stb_o, 1);
    stop = 1'b1;
    load_we = 1'b1; load_addr = 0; load_data = {OP_WRITE, 6'b0, 32'hDEAD_BEEF}; load_off = REG_FB1_BASE;
    @(negedge clk);
    stop = 1'b0; load_we = 1'b0;
    wait_done("t6_done", 100, dc);
    chk("t6_ntxn", n_txn - base, 2);
    chk("t6_pc", pc, 1);
    chk("t6_busy", busy, 0);
    loop_en = 1'b0;
    exp_q.push_back('{32'h0400_0040, 32'h1234_5678, 1, 0}); lat_q.push_back(0);
    base = n_txn;
    do_start(sc);
    wait_done("t6_readback_done", 100, dc);
    chk("t6_readback_ntxn", n_txn - base, 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_copper.md
Name: vga_copper

Overview:
- Display-list sequencer that drives the VGA core's Wishbone slave as a bus master.
- Executes a small command list of register writes, delays and end markers from an internal command RAM.
- Wait-for-condition writes (register offset 0x18) stall on the slave's held-off ack, so the list can reprogram sprites, colours and background mid-frame at exact beam positions without CPU involvement.
- Sits between a CPU-side loader port and the VGA core register bus.

Parameters:
- DEPTH, 64, number of command entries; must be a power of two.
- AW, 6, command address width; equals log2(DEPTH).
- TIMEOUT_W, 21, width of the ack watchdog counter; timeout fires at 2^TIMEOUT_W-1 cycles, which is longer than one 800x525 frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- load_we  in  1  command RAM write strobe
- load_addr  in  AW  command RAM write address
- load_data  in  40  command entry: [39:38] op, [37:32] reserved, [31:0] payload
- load_off  in  8  register offset for WRITE entries; stored with the entry (RAM is 48 bits wide internally)
- start  in  1  single-cycle pulse; begins execution at entry 0
- stop  in  1  single-cycle pulse; requests halt
- loop_en  in  1  at END, restart from entry 0 instead of halting
- busy  out  1  list executing
- done  out  1  single-cycle pulse on normal halt
- error  out  1  sticky watchdog timeout flag; cleared by start
- pc  out  AW  address of current entry
- wb_addr_o  out  32  {8'h04, 16'h0, offset}
- wb_data_o  out  32  payload
- wb_sel_o  out  4  constant 4'hF
- wb_we_o  out  1  constant 1
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle; identical to wb_stb_o
- wb_ack_i  in  1  slave acknowledge

Behaviour:
- Reset (reset==0 at posedge): state IDLE. busy, done, error, pc, wb_stb_o, wb_cyc_o, wb_addr_o, wb_data_o all 0. RAM contents are not reset.
- Ops:
  - 0 WRITE: one Wishbone write of payload to load_off.
  - 1 DELAY: idle payload[19:0] cycles; 0 means no delay.
  - 2 END: end of list.
  - 3 NOP: skip.
- Command RAM: synchronous read with one-cycle latency. load_we is honoured only when busy==0. A write and start in the same cycle: the write lands before entry 0 is fetched.
- States: IDLE, FETCH, DECODE, ISSUE, GAP, DELAY.
  - IDLE: on start, pc<=0, busy<=1, error<=0, go to FETCH. start while busy is ignored.
  - FETCH: present pc to RAM; go to DECODE.
  - DECODE, by op:
    - WRITE: drive addr/data, assert stb/cyc, clear watchdog, go to ISSUE.
    - DELAY: load counter, go to DELAY.
    - NOP: pc++, go to FETCH.
    - END: if loop_en, pc<=0 and go to FETCH; else busy<=0, done<=1, go to IDLE.
  - ISSUE: hold stb/cyc and data stable until ack.
    - On ack: deassert stb/cyc, pc++, go to GAP.
    - Watchdog saturates: deassert stb/cyc, error<=1, busy<=0, go to IDLE. done is not pulsed.
  - GAP: one mandatory idle cycle. The slave keeps ack high while stb is high and clears it one cycle after stb drops; back-to-back strobes would alias the stale ack. Go to FETCH.
  - DELAY: decrement the counter; at 0, pc++ and go to FETCH.
- Minimum WRITE cost: FETCH + DECODE + ISSUE (1 cycle if ack arrives next edge) + GAP = 4 cycles.
- pc wrap: an increment past DEPTH-1 wraps to 0. No END is required; the list loops implicitly regardless of loop_en.
- stop: latched as pending.
  - Honoured at the next FETCH: busy<=0, done<=1, go to IDLE.
  - A transaction in ISSUE is never abandoned by stop; only the watchdog abandons it.
  - Pending stop is cleared on halt and on start.
- stop and start in the same cycle while IDLE: start wins; the stop is discarded.
- done is high for exactly one cycle per halt.

Decomposition:
- Shared package vga_pkg:
  - opcode constants OP_WRITE/OP_DELAY/OP_END/OP_NOP
  - VGA_BASE = 8'h04
  - register offset constants 0x00..0x50, including REG_WAIT_COND = 8'h18
  - state enum for the FSM
- One sub-module, vga_cmd_ram: DEPTH x 48 simple dual-port RAM with synchronous read. Sequencer FSM and watchdog stay in vga_copper.

Test Plan:
- Load [WRITE 0x1C=0x00F0_0ABC, END], pulse start, slave acks next cycle -> one strobe at addr 0x0400001C with data 0x00F00ABC; done pulses exactly 4 cycles after the strobe is first asserted; busy returns to 0; pc=1.
- Two consecutive WRITEs -> wb_stb_o low for at least 1 cycle between them; with the slave model holding ack high while stb is high, exactly 2 transactions are counted.
- [WRITE 0x18=0x0300_0064, WRITE 0x1C=1, END], slave withholds ack for 500 cycles -> stb held 500 cycles with data/addr stable; second write follows; error=0.
- [DELAY 10, WRITE 0x0C=0xAAAA5555, END] -> strobe starts 10 cycles later than a no-delay run.
- TIMEOUT_W=4, slave never acks -> stb drops after 15 cycles; error=1; busy=0; no done pulse; the next start clears error.
- loop_en=1 with [WRITE, END]; stop pulsed while in ISSUE -> the transaction completes on ack, then halt with a done pulse; load_we while busy leaves the RAM unchanged (verified by readback run).
